debug_reg_dumper: RTL and testbench



---
 rtl/debug_reg_dumper_pkg.sv | 19 +
 rtl/debug_reg_dumper_word_serializer.sv | 55 +++++
 rtl/debug_reg_dumper.sv | 131 +++++++++++++
 tb/tb_debug_reg_dumper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_reg_dumper_pkg.sv
// Shared constants and FSM encoding for the debug register dumper.
package debug_reg_dumper_pkg;

  localparam int unsigned LEN_DATA       = 32;
  localparam int unsigned NUM_BITS       = 5;
  localparam int unsigned DEPTH          = 32;
  localparam int unsigned LEN_BYTE       = 8;
  localparam int unsigned BYTES_PER_WORD = LEN_DATA / LEN_BYTE;
  localparam int unsigned BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/debug_reg_dumper_word_serializer.sv
// Holds one register word and hands it out MSB-first, one byte at a time.
module debug_reg_dumper_word_serializer
  import debug_reg_dumper_pkg::*;
#(
  parameter int unsigned len_data = LEN_DATA,
  parameter int unsigned len_byte = LEN_BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  input  logic [len_data-1:0] word_in,
  output logic [len_byte-1:0] byte_out_c,
  output logic                last_byte
);

  localparam int unsigned BPW   = len_data / len_byte;
  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [len_data-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                last_byte_q, last_byte_d;

  // Next word/byte position; load wins over advance.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (load) begin
      shift_d    = word_in;
      byte_cnt_d = '0;
    end else if (advance) begin
      shift_d    = shift_q << len_byte;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
    last_byte_d = (byte_cnt_d == CNT_W'(BPW - 1));
  end

  // Shift register, byte counter and last-byte flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      last_byte_q <= (BPW == 1);
    end else begin
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      last_byte_q <= last_byte_d;
    end
  end

  // Byte that will be at the top once this cycle's load/advance lands.
  assign byte_out_c = shift_d[len_data-1 -: len_byte];
  assign last_byte  = last_byte_q;

endmodule

// File: rtl/debug_reg_dumper.sv
// Dumps every register over the UART TX handshake on a rising halt edge.
module debug_reg_dumper
  import debug_reg_dumper_pkg::*;
#(
  parameter int unsigned len_data = LEN_DATA,
  parameter int unsigned num_bits = NUM_BITS,
  parameter int unsigned depth    = DEPTH,
  parameter int unsigned len_byte = LEN_BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt_flag_d,
  output logic [num_bits-1:0] read_register,
  input  logic [len_data-1:0] read_data,
  output logic [len_byte-1:0] tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  output logic                busy,
  output logic                dump_done
);

  state_e              state_q, state_d;
  logic                halt_prev_q, halt_prev_d;
  logic [num_bits-1:0] reg_idx_q, reg_idx_d;
  logic [len_byte-1:0] tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                dump_done_q, dump_done_d;

  logic                ser_load_c;
  logic                ser_advance_c;
  logic [len_byte-1:0] ser_byte_c;
  logic                ser_last_byte;

  debug_reg_dumper_word_serializer #(
    .len_data (len_data),
    .len_byte (len_byte)
  ) u_word_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (ser_load_c),
    .advance    (ser_advance_c),
    .word_in    (read_data),
    .byte_out_c (ser_byte_c),
    .last_byte  (ser_last_byte)
  );

  // Next state and registered-output lookahead.
  always_comb begin
    state_d       = state_q;
    halt_prev_d   = halt_flag_d;
    reg_idx_d     = reg_idx_q;
    tx_data_d     = tx_data_q;
    ser_load_c    = 1'b0;
    ser_advance_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (halt_flag_d && !halt_prev_q) begin
          reg_idx_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ser_load_c = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (ser_last_byte) begin
            if (reg_idx_q == num_bits'(depth - 1)) begin
              state_d = ST_DONE;
            end else begin
              reg_idx_d = reg_idx_q + num_bits'(1);
              state_d   = ST_LOAD;
            end
          end else begin
            ser_advance_c = 1'b1;
            state_d       = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        reg_idx_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    tx_start_d  = (state_d == ST_SEND);
    busy_d      = (state_d != ST_IDLE);
    dump_done_d = (state_d == ST_DONE);
    if (state_d == ST_SEND) begin
      tx_data_d = ser_byte_c;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      halt_prev_q <= 1'b0;
      reg_idx_q   <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_prev_q <= halt_prev_d;
      reg_idx_q   <= reg_idx_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign read_register = reg_idx_q;
  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign busy          = busy_q;
  assign dump_done     = dump_done_q;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Randomized bench for debug_reg_dumper with a byte-stream reference model.
module tb_debug_reg_dumper;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_flag_d;
  logic        tx_done;
  logic [4:0]  read_register;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        dump_done;

  logic [31:0] rf [32];
  assign read_data = rf[read_register];

  debug_reg_dumper dut (
    .clk           (clk),
    .reset         (reset),
    .halt_flag_d   (halt_flag_d),
    .read_register (read_register),
    .read_data     (read_data),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_done       (tx_done),
    .busy          (busy),
    .dump_done     (dump_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected stream: {register index, byte}
  logic [15:0] exp_q [$];
  int          byte_idx      = 0;
  int          dump_done_cnt = 0;
  int          resp_cnt      = 0;
  int          stall_idx     = -1;
  int          spur_send_idx = -1;
  int          fixed_delay   = 0;
  logic        spur_idle_req = 1'b0;
  logic [7:0]  held_byte     = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Every register, most significant byte first, in address order.
  task automatic fill_expected();
    exp_q.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back({8'(r), 8'(rf[r] >> (8 * b))});
  endtask

  // UART side: answers each tx_start with tx_done and checks the stream.
  initial begin
    int d;
    logic [15:0] e;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (reset) begin
        resp_cnt = 0;
      end else begin
        if (spur_idle_req) begin
          tx_done       = 1'b1;
          spur_idle_req = 1'b0;
        end
        if (resp_cnt > 0) begin
          check("hold_tx_data", 32'(tx_data), 32'(held_byte));
          check("no_start_while_waiting", 32'(tx_start), 32'd0);
          resp_cnt--;
          if (resp_cnt == 0) tx_done = 1'b1;
        end else if (tx_start) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tx_start", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(tx_data), 32'(e[7:0]));
            check("read_register", 32'(read_register), 32'(e[15:8]));
          end
          held_byte = tx_data;
          if (byte_idx == stall_idx) d = 50;
          else if (fixed_delay > 0) d = fixed_delay;
          else d = int'($urandom_range(4, 1));
          if (byte_idx == spur_send_idx) tx_done = 1'b1;
          byte_idx++;
          resp_cnt = d;
        end
        if (dump_done) begin
          dump_done_cnt++;
          check("done_after_last_byte", 32'(exp_q.size()), 32'd0);
          check("busy_at_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic start_dump();
    halt_flag_d = 1'b0;
    repeat (2) @(negedge clk);
    fill_expected();
    byte_idx    = 0;
    halt_flag_d = 1'b1;
    @(negedge clk);
    check("lat_no_start_in_load", 32'(tx_start), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_first_start", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 4000 && byte_idx < n; i++) @(negedge clk);
    check("reach_byte", 32'(byte_idx >= n), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 4000 && dump_done_cnt < target; i++) @(negedge clk);
    check("dump_done_seen", 32'(dump_done_cnt), 32'(target));
    check("byte_total", 32'(byte_idx), 32'd128);
    @(negedge clk);
    check("busy_falls", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(dump_done), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_dump_done"}, 32'(dump_done), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_read_register"}, 32'(read_register), 32'd0);
  endtask

  initial begin
    int saved_done;
    reset       = 1'b1;
    halt_flag_d = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA0B0_0000 + 32'(i);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Spurious tx_done while idle
    spur_idle_req = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_spur_busy", 32'(busy), 32'd0);

    // Dump A: fixed pattern, stall on byte 5, spurious tx_done in a SEND cycle
    fixed_delay   = 3;
    stall_idx     = 5;
    spur_send_idx = 10;
    start_dump();
    wait_done(1);
    stall_idx     = -1;
    spur_send_idx = -1;

    // Halt still high after DONE: no restart
    repeat (20) @(negedge clk);
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_restart_done_cnt", 32'(dump_done_cnt), 32'd1);

    // Dump B: random data and delays, halt toggled mid-dump
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    fixed_delay = 0;
    start_dump();
    wait_bytes(40);
    halt_flag_d = 1'b0;
    repeat (3) @(negedge clk);
    halt_flag_d = 1'b1;
    wait_done(2);
    repeat (20) @(negedge clk);
    check("retrigger_no_second_dump", 32'(dump_done_cnt), 32'd2);

    // Dump C: reset mid-dump at byte 70
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    start_dump();
    wait_bytes(70);
    saved_done  = dump_done_cnt;
    reset       = 1'b1;
    halt_flag_d = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_hold");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);
    check("no_done_on_reset", 32'(dump_done_cnt), 32'(saved_done));

    // Dump D: restarts from reg0 byte3
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    start_dump();
    wait_done(saved_done + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
